// File: rtl/multi_clock_div.sv
// multi_clock_div
//
// Programmable multi-channel clock divider. Each channel produces a
// one-cycle tick (a clock enable on clk) once every D enabled cycles, and a
// 50%-duty square wave that toggles on every tick (period 2D). Divisors are
// written at run time through a single shared write port. A write lands
// in a per-channel pending slot and is promoted to the active divisor only
// at the channel's next period boundary, so a period is never cut short or
// stretched by a ratio change.
//
// clk_out is meant for debug / LED drive only; downstream logic must use
// tick as a clock enable and never clock anything from clk_out.
//
// Parameters
//   WIDTH        divisor / counter width
//   CHANNELS     number of independent channels (>= 1)
//   DEFAULT_DIV  divisor loaded into every channel at reset
//   CH_W         width of cfg_ch, derived from CHANNELS (min 1)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   enable       per-channel run enable (level)
//   cfg_we       one-cycle divisor write strobe
//   cfg_ch       channel addressed by the write (out-of-range is dropped)
//   cfg_div      new divisor; 0 stops the channel once applied
//   tick         per-channel one-cycle pulse every D running cycles
//   clk_out      per-channel divided square wave
//   cfg_pending  per-channel flag: a written divisor awaits its boundary

module multi_clock_div #(
  parameter int                 WIDTH       = 32,
  parameter int                 CHANNELS    = 4,
  parameter logic [WIDTH-1:0]   DEFAULT_DIV = 50,
  localparam int                CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] cfg_pending
);

  // CHANNELS never exceeds 2^CH_W, so it always fits in CH_W+1 bits.
  localparam logic [CH_W:0] CH_LIM = CHANNELS[CH_W:0];

  logic [WIDTH-1:0]    cnt      [CHANNELS];
  logic [WIDTH-1:0]    div_q    [CHANNELS];
  logic [WIDTH-1:0]    pend_div [CHANNELS];
  logic [CHANNELS-1:0] pend_v;
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] clk_out_q;

  logic [CHANNELS-1:0] running;
  logic [CHANNELS-1:0] at_end;
  logic [CHANNELS-1:0] boundary;
  logic [CHANNELS-1:0] wr_hit;
  logic                ch_ok;

  // Per-channel decode of the current cycle. An idle channel (disabled
  // or divisor 0) is treated as sitting on a boundary every cycle, which
  // lets a pending or freshly written divisor take effect immediately.
  always_comb begin
    ch_ok    = ({1'b0, cfg_ch} < CH_LIM);
    running  = '0;
    at_end   = '0;
    boundary = '0;
    wr_hit   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      running[i]  = enable[i] && (div_q[i] != '0);
      // Compared in WIDTH bits; with div_q=1 this is true every cycle.
      at_end[i]   = (cnt[i] == (div_q[i] - WIDTH'(1)));
      boundary[i] = !running[i] || at_end[i];
      wr_hit[i]   = cfg_we && ch_ok && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i]      <= '0;
        div_q[i]    <= DEFAULT_DIV;
        pend_div[i] <= '0;
      end
      pend_v    <= '0;
      tick_q    <= '0;
      clk_out_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        // Counter / output generation
        if (running[i]) begin
          if (at_end[i]) begin
            cnt[i]       <= '0;
            tick_q[i]    <= 1'b1;
            clk_out_q[i] <= ~clk_out_q[i];
          end else begin
            cnt[i]    <= cnt[i] + WIDTH'(1);
            tick_q[i] <= 1'b0;
          end
        end else begin
          // Leaving the running state discards the partial period.
          cnt[i]       <= '0;
          tick_q[i]    <= 1'b0;
          clk_out_q[i] <= 1'b0;
        end

        // Divisor update: a write in the boundary cycle bypasses the
        // pending slot and beats any older pending value.
        if (boundary[i]) begin
          if (wr_hit[i]) begin
            div_q[i]  <= cfg_div;
            pend_v[i] <= 1'b0;
          end else if (pend_v[i]) begin
            div_q[i]  <= pend_div[i];
            pend_v[i] <= 1'b0;
          end
        end else if (wr_hit[i]) begin
          pend_div[i] <= cfg_div;
          pend_v[i]   <= 1'b1;
        end
      end
    end
  end

  assign tick        = tick_q;
  assign clk_out     = clk_out_q;
  assign cfg_pending = pend_v;

endmodule
